// File: rtl/pooling_max_unit_if.sv
// Stream bundle between the pooling input interface, the max unit and the output stage.
// The master drives words in and consumes window results; the slave is the max unit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface pooling_max_unit_if #(
  parameter int ROW_WIDTH = 3
);
  logic                   clear;
  logic                   input_valid;
  logic [`DATA_WIDTH-1:0] data_in;
  logic                   out_valid;
  logic [`DATA_WIDTH-1:0] data_out;
  logic [ROW_WIDTH-1:0]   out_col;
  logic                   row_done;

  modport master (
    output clear, input_valid, data_in,
    input  out_valid, data_out, out_col, row_done
  );

  modport slave (
    input  clear, input_valid, data_in,
    output out_valid, data_out, out_col, row_done
  );
endinterface

// File: rtl/pooling_max_unit.sv
// Streaming POOL_SIZE x POOL_SIZE max pooling of row-major IEEE-754 words.
// Horizontal maxima are accumulated on the fly; vertical maxima live in a per-group partial buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_max_unit #(
  parameter int POOL_SIZE  = 2,
  parameter int IN_ROW_LEN = 6,
  parameter int ROW_WIDTH  = 3
) (
  input logic               clk,
  input logic               rst_n,
  pooling_max_unit_if.slave bus
);
  localparam int DW          = `DATA_WIDTH;
  localparam int OUT_ROW_LEN = IN_ROW_LEN / POOL_SIZE;
  localparam int PW          = $clog2(POOL_SIZE);

  // Bit-level float max; equal patterns keep the stored operand a.
  function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    if (a[DW-1] != b[DW-1])
      r = a[DW-1] ? b : a;
    else if (!a[DW-1])
      r = (b[DW-2:0] > a[DW-2:0]) ? b : a;
    else
      r = (b[DW-2:0] < a[DW-2:0]) ? b : a;
    return r;
  endfunction

  // The column counter is kept split as (group, position within group) to avoid a divider.
  logic [PW-1:0]        sub_q, sub_d;
  logic [ROW_WIDTH-1:0] grp_q, grp_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [DW-1:0]        h_acc_q, h_acc_d;
  logic [DW-1:0]        part_q [OUT_ROW_LEN];
  logic [DW-1:0]        part_d [OUT_ROW_LEN];
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        data_out_q, data_out_d;
  logic [ROW_WIDTH-1:0] out_col_q, out_col_d;
  logic                 row_done_q, row_done_d;

  logic [DW-1:0] h_fin;
  logic [DW-1:0] part_sel;
  logic          grp_end;
  logic          last_grp;

  always_comb begin
    sub_d       = sub_q;
    grp_d       = grp_q;
    phase_d     = phase_q;
    h_acc_d     = h_acc_q;
    part_d      = part_q;
    out_valid_d = 1'b0;
    row_done_d  = 1'b0;
    data_out_d  = data_out_q;
    out_col_d   = out_col_q;
    h_fin       = fmax(h_acc_q, bus.data_in);
    grp_end     = (sub_q == PW'(POOL_SIZE - 1));
    last_grp    = (grp_q == ROW_WIDTH'(OUT_ROW_LEN - 1));
    part_sel    = '0;
    for (int i = 0; i < OUT_ROW_LEN; i++)
      if (grp_q == ROW_WIDTH'(i)) part_sel = part_q[i];

    if (bus.clear) begin
      sub_d   = '0;
      grp_d   = '0;
      phase_d = '0;
    end else if (bus.input_valid) begin
      h_acc_d = (sub_q == '0) ? bus.data_in : h_fin;

      if (grp_end) begin
        if (phase_q == PW'(POOL_SIZE - 1)) begin
          data_out_d  = fmax(part_sel, h_fin);
          out_col_d   = grp_q;
          out_valid_d = 1'b1;
          row_done_d  = last_grp;
        end else begin
          for (int i = 0; i < OUT_ROW_LEN; i++)
            if (grp_q == ROW_WIDTH'(i))
              part_d[i] = (phase_q == '0) ? h_fin : fmax(part_q[i], h_fin);
        end

        sub_d = '0;
        if (last_grp) begin
          grp_d   = '0;
          phase_d = (phase_q == PW'(POOL_SIZE - 1)) ? '0 : phase_q + PW'(1);
        end else begin
          grp_d = grp_q + ROW_WIDTH'(1);
        end
      end else begin
        sub_d = sub_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q       <= '0;
      grp_q       <= '0;
      phase_q     <= '0;
      h_acc_q     <= '0;
      for (int i = 0; i < OUT_ROW_LEN; i++) part_q[i] <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_col_q   <= '0;
      row_done_q  <= 1'b0;
    end else begin
      sub_q       <= sub_d;
      grp_q       <= grp_d;
      phase_q     <= phase_d;
      h_acc_q     <= h_acc_d;
      part_q      <= part_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_col_q   <= out_col_d;
      row_done_q  <= row_done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.out_col   = out_col_q;
  assign bus.row_done  = row_done_q;
endmodule

// File: tb/tb_pooling_max_unit.sv
// Self-checking bench for pooling_max_unit: window-max reference model plus directed literal checks.
module tb_pooling_max_unit;
  localparam int P  = 2;
  localparam int IN = 6;
  localparam int RW = 3;

  logic clk;
  logic rst_n;

  pooling_max_unit_if #(.ROW_WIDTH(RW)) bus ();

  pooling_max_unit #(.POOL_SIZE(P), .IN_ROW_LEN(IN), .ROW_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: total order on float bit patterns, +0 above -0.
  function automatic longint fkey(input logic [31:0] w);
    longint m;
    m = longint'(w[30:0]);
    return w[31] ? (-m - 1) : m;
  endfunction

  logic [31:0] frame [$];
  logic        exp_v, exp_rd;
  logic [31:0] exp_d;
  logic [RW-1:0] exp_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame.delete();
      exp_v = 1'b0; exp_rd = 1'b0; exp_d = '0; exp_c = '0;
    end else begin
      exp_v = 1'b0;
      exp_rd = 1'b0;
      if (bus.clear) begin
        frame.delete();
      end else if (bus.input_valid) begin
        int n, r, c;
        logic [31:0] best, w;
        frame.push_back(bus.data_in);
        n = frame.size() - 1;
        r = n / IN;
        c = n % IN;
        if ((r % P == P - 1) && (c % P == P - 1)) begin
          best = frame[(r - P + 1) * IN + (c - P + 1)];
          for (int rr = r - P + 1; rr <= r; rr++)
            for (int cc = c - P + 1; cc <= c; cc++) begin
              w = frame[rr * IN + cc];
              if (fkey(w) > fkey(best)) best = w;
            end
          exp_v  = 1'b1;
          exp_d  = best;
          exp_c  = RW'(c / P);
          exp_rd = (c == IN - 1);
        end
      end
    end
  end

  logic [31:0] log_d [$];
  int          log_c [$];
  logic        log_r [$];

  always @(negedge clk) begin
    checks++;
    if (bus.out_valid !== exp_v || bus.row_done !== exp_rd ||
        bus.data_out !== exp_d || bus.out_col !== exp_c) begin
      errors++;
      $display("FAIL model t=%0t got v=%b rd=%b d=%h c=%0d want v=%b rd=%b d=%h c=%0d",
               $time, bus.out_valid, bus.row_done, bus.data_out, bus.out_col,
               exp_v, exp_rd, exp_d, exp_c);
    end
    if (bus.out_valid === 1'b1) begin
      log_d.push_back(bus.data_out);
      log_c.push_back(int'(bus.out_col));
      log_r.push_back(bus.row_done);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic log_reset();
    log_d.delete(); log_c.delete(); log_r.delete();
  endtask

  // Literal expectations for a scenario: want lists of data/col/row_done per pulse.
  task automatic verify(input string name, input logic [31:0] wd[$], input int wc[$], input logic wr[$]);
    chk({name, "_count"}, 64'(log_d.size()), 64'(wd.size()));
    for (int i = 0; i < wd.size() && i < log_d.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), 64'(log_d[i]), 64'(wd[i]));
      chk($sformatf("%s_col%0d", name, i), 64'(log_c[i]), 64'(wc[i]));
      chk($sformatf("%s_rd%0d", name, i), 64'(log_r[i]), 64'(wr[i]));
    end
  endtask

  task automatic send(input logic [31:0] w);
    bus.input_valid = 1'b1;
    bus.data_in     = w;
    @(negedge clk);
    bus.input_valid = 1'b0;
  endtask

  task automatic send_all(input logic [31:0] s[$], input int gap);
    foreach (s[i]) begin
      send(s[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({name, "_data"},  64'(bus.data_out),  64'(0));
    chk({name, "_col"},   64'(bus.out_col),   64'(0));
    chk({name, "_rd"},    64'(bus.row_done),  64'(0));
  endtask

  logic [31:0] f1 [$];
  logic [31:0] f2 [$];
  logic [31:0] f3 [$];
  logic [31:0] e1d [$];
  int          e1c [$];
  logic        e1r [$];

  initial begin
    f1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'hBF800000, 32'hC0000000,
           32'h00000000, 32'h00000000, 32'h40800000, 32'h3F800000, 32'hC0000000, 32'hBF800000};
    f2 = '{32'h80000000, 32'h00000000, 32'hC0000000, 32'hBF800000, 32'h3F800000, 32'h3F800000,
           32'h80000000, 32'h80000000, 32'hC0400000, 32'hC0800000, 32'h3F800000, 32'h3F800000};
    f3 = '{32'h40A00000, 32'h3F800000, 32'h00000000, 32'h80000000, 32'hC0400000, 32'hC0400000,
           32'h3F800000, 32'h40C00000, 32'h80000000, 32'hBF800000, 32'hC0800000, 32'hC0400000};
    e1d = '{32'h40000000, 32'h40800000, 32'hBF800000};
    e1c = '{0, 1, 2};
    e1r = '{1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    bus.clear = 1'b0;
    bus.input_valid = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    log_reset();
    send_all(f1, 0);
    repeat (2) @(negedge clk);
    verify("basic", e1d, e1c, e1r);

    log_reset();
    send_all(f2, 0);
    repeat (2) @(negedge clk);
    verify("zeros_neg", '{32'h00000000, 32'hBF800000, 32'h3F800000}, '{0, 1, 2}, '{1'b0, 1'b0, 1'b1});

    log_reset();
    send_all(f1, 3);
    repeat (2) @(negedge clk);
    verify("gapped", e1d, e1c, e1r);

    // Clear mid-row, with a word offered in the clear cycle that must be dropped.
    send_all('{32'h42000000, 32'h42000000, 32'h42000000}, 0);
    bus.clear = 1'b1;
    bus.input_valid = 1'b1;
    bus.data_in = 32'h42800000;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.input_valid = 1'b0;
    chk("clear_valid", 64'(bus.out_valid), 64'(0));
    log_reset();
    send_all(f1, 0);
    repeat (2) @(negedge clk);
    verify("clear", e1d, e1c, e1r);

    log_reset();
    send_all(f1, 0);
    send_all(f3, 0);
    repeat (2) @(negedge clk);
    verify("multirow",
           '{32'h40000000, 32'h40800000, 32'hBF800000, 32'h40C00000, 32'h00000000, 32'hC0400000},
           '{0, 1, 2, 0, 1, 2},
           '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});

    // Asynchronous reset mid-window while data_out still holds a nonzero result.
    send_all('{32'h41000000, 32'h41000000, 32'h41000000}, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    log_reset();
    send_all(f1, 0);
    repeat (2) @(negedge clk);
    verify("post_rst", e1d, e1c, e1r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pooling_max_unit.md
Name: pooling_max_unit

Overview:
Downstream consumer of the pooling input interface's serial word stream. It receives one IEEE-754 single-precision word per valid cycle, in row-major order, and produces one word per POOL_SIZE x POOL_SIZE window: the window's maximum. Horizontal maxima are built on the fly. Vertical maxima use a partial-result line buffer of OUT_ROW_LEN entries. Results go to the pooling output/storage stage.

Parameters:
POOL_SIZE, 2, window edge length (>=2); horizontal and vertical stride equal POOL_SIZE.
IN_ROW_LEN, 6, input words per feature-map row; must be a multiple of POOL_SIZE.
ROW_WIDTH, 3, width of column/group counters; 2^ROW_WIDTH >= IN_ROW_LEN.
(derived) OUT_ROW_LEN = IN_ROW_LEN/POOL_SIZE, number of partial buffer entries.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
clear  input  1  synchronous restart: zero counters and out_valid; buffer contents are don't-care.
input_valid  input  1  data_in is valid this cycle.
data_in  input  `DATA_WIDTH (32)  IEEE-754 single word.
out_valid  output  1  one-cycle pulse; data_out/out_col valid.
data_out  output  `DATA_WIDTH  window maximum.
out_col  output  ROW_WIDTH  output column index, 0..OUT_ROW_LEN-1.
row_done  output  1  asserted with out_valid on the last window of an output row.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). All state and outputs go to 0 during reset: out_valid=0, data_out=0, out_col=0, row_done=0, counters=0, h_acc=0, partial buffer=0.
- Counters advance only on input_valid=1. Gaps of any length hold all state.
  - col: 0..IN_ROW_LEN-1, wraps to 0.
  - phase (row within window): increments when col wraps; counts 0..POOL_SIZE-1, then wraps.
- Group index g = col/POOL_SIZE. Group end is col%POOL_SIZE == POOL_SIZE-1.
- Horizontal accumulation:
  - First word of a group loads h_acc.
  - Each later word forms h = fmax(h_acc, data_in).
  - At group end, combinational h_fin = fmax(h_acc, data_in) is handed to the vertical stage.
- Vertical stage at group end:
  - phase==0: buf[g] <= h_fin.
  - 0<phase<POOL_SIZE-1: buf[g] <= fmax(buf[g], h_fin).
  - phase==POOL_SIZE-1: data_out <= fmax(buf[g], h_fin), out_col <= g, out_valid <= 1, row_done <= (g==OUT_ROW_LEN-1).
- Latency: out_valid rises exactly 1 cycle after the edge that samples the window's last word. out_valid and row_done are single-cycle pulses.
- data_out and out_col hold their values until the next output.
- fmax(a,b) is a pure bit-level compare; no FP unit.
  - Signs differ: the non-negative operand wins, so +0 beats -0.
  - Both positive: larger magnitude bits win.
  - Both negative: smaller magnitude bits win.
  - Equal bit patterns: return a, the earlier/stored operand.
- NaN/Inf inputs are out of contract. Results for them are bit-compare order only; no flagging.
- clear together with input_valid: clear wins and the word is dropped.
- Async reset mid-window discards the partial window. The next accepted word is treated as col=0, phase=0.
- No backpressure: downstream must accept every out_valid pulse.

Test Plan:
- Reset check: assert rst_n=0 mid-stream -> all outputs 0 immediately, asynchronously; after release, first word is col 0.
- POOL_SIZE=2, IN_ROW_LEN=6, row0 = 1,2,3,4,-1,-2, row1 = 0,0,4,1,-2,-1 (floats) -> 3 pulses:
  - out_col 0 data 0x40000000 (2.0), 1 cycle after the 2nd word of row1.
  - out_col 1 data 0x40800000 (4.0).
  - out_col 2 data 0xBF800000 (-1.0), with row_done=1.
- Signed-zero window: words -0, +0, -0, -0 (0x80000000, 0x00000000, 0x80000000, 0x80000000) -> data_out 0x00000000.
- All-negative window: -2, -1, -3, -4 -> data_out 0xBF800000.
- Gapped input: same stream as the 6-wide scenario with input_valid low for 3 cycles between every word -> identical outputs and out_col sequence; each pulse 1 cycle after its last word.
- Clear mid-row: after 3 words, pulse clear, then feed a fresh 2-row frame -> outputs match the fresh frame only; no stale-buffer output.
- Multi-row: 4 rows streamed back-to-back with no gaps -> 6 outputs, row_done on pulses 3 and 6, out_col sequence 0,1,2,0,1,2.
